// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI4-Lite single-outstanding master: FSM states and response codes.
package axi_lite_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StWrite,
      StWresp,
      StRaddr,
      StRdata
   } state_e;

   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespExokay = 2'b01;
   localparam logic [1:0] RespSlverr = 2'b10;
   localparam logic [1:0] RespDecerr = 2'b11;

endpackage

// File: rtl/axi_lite_master.sv
// AXI4-Lite master: turns one user command at a time into an AXI read or write
// and reports completion with a single-cycle rsp_valid pulse.
module axi_lite_master
   import axi_lite_pkg::*;
#(
   parameter int C_M00_AXI_DATA_WIDTH = 32,
   parameter int C_M00_AXI_ADDR_WIDTH = 4
) (
   input  logic                                m00_axi_aclk,
   input  logic                                m00_axi_aresetn,
   // user command / response
   input  logic                                cmd_valid,
   output logic                                cmd_ready,
   input  logic                                cmd_we,
   input  logic [C_M00_AXI_ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [C_M00_AXI_DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [C_M00_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
   output logic                                rsp_valid,
   output logic [C_M00_AXI_DATA_WIDTH-1:0]     rsp_rdata,
   output logic [1:0]                          rsp_resp,
   // AW channel
   output logic [C_M00_AXI_ADDR_WIDTH-1:0]     m00_axi_awaddr,
   output logic [2:0]                          m00_axi_awprot,
   output logic                                m00_axi_awvalid,
   input  logic                                m00_axi_awready,
   // W channel
   output logic [C_M00_AXI_DATA_WIDTH-1:0]     m00_axi_wdata,
   output logic [C_M00_AXI_DATA_WIDTH/8-1:0]   m00_axi_wstrb,
   output logic                                m00_axi_wvalid,
   input  logic                                m00_axi_wready,
   // B channel
   input  logic [1:0]                          m00_axi_bresp,
   input  logic                                m00_axi_bvalid,
   output logic                                m00_axi_bready,
   // AR channel
   output logic [C_M00_AXI_ADDR_WIDTH-1:0]     m00_axi_araddr,
   output logic [2:0]                          m00_axi_arprot,
   output logic                                m00_axi_arvalid,
   input  logic                                m00_axi_arready,
   // R channel
   input  logic [C_M00_AXI_DATA_WIDTH-1:0]     m00_axi_rdata,
   input  logic [1:0]                          m00_axi_rresp,
   input  logic                                m00_axi_rvalid,
   output logic                                m00_axi_rready
);

   localparam int DW = C_M00_AXI_DATA_WIDTH;
   localparam int AW = C_M00_AXI_ADDR_WIDTH;
   localparam int SW = C_M00_AXI_DATA_WIDTH / 8;

   state_e         state_q, state_d;
   logic [AW-1:0]  addr_q, addr_d;
   logic [DW-1:0]  wdata_q, wdata_d;
   logic [SW-1:0]  wstrb_q, wstrb_d;
   logic           aw_done_q, aw_done_d;
   logic           w_done_q, w_done_d;
   logic           rsp_valid_q, rsp_valid_d;
   logic [DW-1:0]  rsp_rdata_q, rsp_rdata_d;
   logic [1:0]     rsp_resp_q, rsp_resp_d;

   logic aw_fire, w_fire, ar_fire;

   always_ff @(posedge m00_axi_aclk) begin
      if (!m00_axi_aresetn) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= RespOkay;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_resp_q  <= rsp_resp_d;
      end
   end

   assign aw_fire = m00_axi_awvalid & m00_axi_awready;
   assign w_fire  = m00_axi_wvalid & m00_axi_wready;
   assign ar_fire = m00_axi_arvalid & m00_axi_arready;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;

      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               addr_d    = cmd_addr;
               wdata_d   = cmd_wdata;
               wstrb_d   = cmd_wstrb;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = cmd_we ? StWrite : StRaddr;
            end
         end
         StWrite: begin
            // AW and W complete independently, in either order or together
            aw_done_d = aw_done_q | aw_fire;
            w_done_d  = w_done_q | w_fire;
            if (aw_done_d && w_done_d) begin
               state_d = StWresp;
            end
         end
         StWresp: begin
            if (m00_axi_bvalid) begin
               rsp_resp_d  = m00_axi_bresp;
               rsp_rdata_d = '0;
               rsp_valid_d = 1'b1;
               state_d     = StIdle;
            end
         end
         StRaddr: begin
            if (ar_fire) begin
               state_d = StRdata;
            end
         end
         StRdata: begin
            if (m00_axi_rvalid) begin
               rsp_resp_d  = m00_axi_rresp;
               rsp_rdata_d = m00_axi_rdata;
               rsp_valid_d = 1'b1;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign cmd_ready       = (state_q == StIdle);
   assign rsp_valid       = rsp_valid_q;
   assign rsp_rdata       = rsp_rdata_q;
   assign rsp_resp        = rsp_resp_q;

   assign m00_axi_awaddr  = addr_q;
   assign m00_axi_awprot  = 3'b000;
   assign m00_axi_awvalid = (state_q == StWrite) && !aw_done_q;
   assign m00_axi_wdata   = wdata_q;
   assign m00_axi_wstrb   = wstrb_q;
   assign m00_axi_wvalid  = (state_q == StWrite) && !w_done_q;
   assign m00_axi_bready  = (state_q == StWresp);
   assign m00_axi_araddr  = addr_q;
   assign m00_axi_arprot  = 3'b000;
   assign m00_axi_arvalid = (state_q == StRaddr);
   assign m00_axi_rready  = (state_q == StRdata);

endmodule

// File: tb/tb_axi_lite_master.sv
// Randomized bench for axi_lite_master: slave model with per-transaction delays,
// reference register file, scoreboard queue checked by an independent monitor.
module tb_axi_lite_master;
   import axi_lite_pkg::*;

   logic        clk = 1'b0;
   logic        aresetn;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [3:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [3:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;

   axi_lite_master #(.C_M00_AXI_DATA_WIDTH(32), .C_M00_AXI_ADDR_WIDTH(4)) dut (
      .m00_axi_aclk(clk), .m00_axi_aresetn(aresetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .m00_axi_awaddr(awaddr), .m00_axi_awprot(awprot), .m00_axi_awvalid(awvalid),
      .m00_axi_awready(awready),
      .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb), .m00_axi_wvalid(wvalid),
      .m00_axi_wready(wready),
      .m00_axi_bresp(bresp), .m00_axi_bvalid(bvalid), .m00_axi_bready(bready),
      .m00_axi_araddr(araddr), .m00_axi_arprot(arprot), .m00_axi_arvalid(arvalid),
      .m00_axi_arready(arready),
      .m00_axi_rdata(rdata), .m00_axi_rresp(rresp), .m00_axi_rvalid(rvalid),
      .m00_axi_rready(rready)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] rdata;
      logic [1:0]  resp;
      bit          zw;
      int unsigned acc;
   } exp_t;

   typedef struct {
      int unsigned d_aw, d_w, d_ar, d_b, d_r;
      logic [1:0]  resp;
   } cfg_t;

   exp_t        exp_q[$];
   cfg_t        cfg_q[$];
   logic [31:0] mem_ref[4];
   logic [31:0] slv_mem[4];
   int          n_chk = 0;
   int          n_pass = 0;
   int unsigned aw_cyc = 0, w_cyc = 0, rr_cyc = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h required %0h", name, act, req);
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      $display("FAIL %s: got timeout required completion", name);
   endtask

   // ---------------- slave model ----------------
   initial begin
      bit aw_hs, w_hs, ar_hs, b_hs, r_hs, rst_s;
      bit tx_active, aw_got, w_got, pend_b, pend_r;
      int unsigned awcnt, wcnt, arcnt, bcnt, rcnt;
      cfg_t        cur;
      logic [3:0]  aw_a, ar_a;
      logic [31:0] w_d, r_val;
      logic [3:0]  w_s;
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      bresp = 0; rresp = 0; rdata = 0;
      tx_active = 0; aw_got = 0; w_got = 0; pend_b = 0; pend_r = 0;
      awcnt = 0; wcnt = 0; arcnt = 0; bcnt = 0; rcnt = 0; r_val = 0;
      aw_a = 0; ar_a = 0; w_d = 0; w_s = 0;
      cur = '{0, 0, 0, 0, 0, RespOkay};
      forever begin
         @(negedge clk);
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         ar_hs = arvalid && arready;
         b_hs  = bvalid && bready;
         r_hs  = rvalid && rready;
         rst_s = !aresetn;
         if (aw_hs) aw_a = awaddr;
         if (w_hs) begin w_d = wdata; w_s = wstrb; end
         if (ar_hs) ar_a = araddr;
         @(posedge clk);
         #1;
         if (rst_s) begin
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
            tx_active = 0; aw_got = 0; w_got = 0; pend_b = 0; pend_r = 0;
            continue;
         end
         if (aw_hs) begin chk("aw_single_handshake", aw_got, 0); awready = 0; aw_got = 1; end
         if (w_hs) begin chk("w_single_handshake", w_got, 0); wready = 0; w_got = 1; end
         if (b_hs) begin bvalid = 0; tx_active = 0; end
         if (r_hs) begin rvalid = 0; tx_active = 0; end
         if (aw_got && w_got) begin
            aw_got = 0; w_got = 0; pend_b = 1; bcnt = cur.d_b;
            if (cur.resp == RespOkay)
               for (int b = 0; b < 4; b++)
                  if (w_s[b]) slv_mem[aw_a[3:2]][8*b +: 8] = w_d[8*b +: 8];
         end
         if (ar_hs) begin
            arready = 0; pend_r = 1; rcnt = cur.d_r; r_val = slv_mem[ar_a[3:2]];
         end
         if (pend_b) begin
            if (bcnt == 0) begin bvalid = 1; bresp = cur.resp; pend_b = 0; end
            else bcnt--;
         end
         if (pend_r) begin
            if (rcnt == 0) begin rvalid = 1; rdata = r_val; rresp = cur.resp; pend_r = 0; end
            else rcnt--;
         end
         if (!tx_active && (awvalid || arvalid) && cfg_q.size() > 0) begin
            cur = cfg_q.pop_front();
            tx_active = 1; awcnt = cur.d_aw; wcnt = cur.d_w; arcnt = cur.d_ar;
         end
         if (tx_active && awvalid && !awready && !aw_got) begin
            if (awcnt == 0) awready = 1; else awcnt--;
         end
         if (tx_active && wvalid && !wready && !w_got) begin
            if (wcnt == 0) wready = 1; else wcnt--;
         end
         if (tx_active && arvalid && !arready) begin
            if (arcnt == 0) arready = 1; else arcnt--;
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin
      bit          in_flight = 0, rst_chk = 0;
      bit          p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
      bit          p_br = 0, p_bv = 0, p_rr = 0, p_rv = 0, p_rsp = 0;
      logic [3:0]  p_awaddr = 0, p_araddr = 0, p_wstrb = 0;
      logic [31:0] p_wdata = 0;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (!aresetn) begin
            exp_q.delete();
            in_flight = 0; rst_chk = 1;
            p_awv = 0; p_wv = 0; p_arv = 0; p_br = 0; p_rr = 0; p_rsp = 0;
            continue;
         end
         if (rst_chk) begin
            chk("reset_ctrl", {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid,
                               rsp_resp}, {1'b1, 6'b0, 2'b00});
            chk("reset_data", {rsp_rdata, wdata}, 64'h0);
            chk("reset_addr", {awaddr, araddr, wstrb}, 12'h0);
            rst_chk = 0;
         end
         if (p_awv && !p_awr) chk("aw_hold_stable", {awvalid, awaddr}, {1'b1, p_awaddr});
         if (p_wv && !p_wr) chk("w_hold_stable", {wvalid, wstrb, wdata}, {1'b1, p_wstrb, p_wdata});
         if (p_arv && !p_arr) chk("ar_hold_stable", {arvalid, araddr}, {1'b1, p_araddr});
         if (p_br && !p_bv) chk("bready_held", bready, 1);
         if (p_rr && !p_rv) chk("rready_held", rready, 1);
         if (awvalid) chk("awprot", awprot, 0);
         if (arvalid) chk("arprot", arprot, 0);
         if (p_rsp) chk("rsp_single_pulse", rsp_valid, 0);
         if (cmd_ready) chk("idle_quiet", {bready, rready, awvalid, wvalid, arvalid}, 0);
         if (in_flight && cmd_ready) chk("ready_only_in_rsp_cycle", rsp_valid, 1);
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_rsp: got rsp_valid=1 required no response");
            end else begin
               e = exp_q.pop_front();
               chk("rsp_rdata", rsp_rdata, e.rdata);
               chk("rsp_resp", rsp_resp, e.resp);
               if (e.zw) chk("rsp_latency", cyc - e.acc, 3);
            end
         end
         if (rsp_valid) in_flight = 0;
         if (cmd_valid && cmd_ready) in_flight = 1;
         if (awvalid) aw_cyc++;
         if (wvalid) w_cyc++;
         if (rready) rr_cyc++;
         p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
         p_wv = wvalid; p_wr = wready; p_wdata = wdata; p_wstrb = wstrb;
         p_arv = arvalid; p_arr = arready; p_araddr = araddr;
         p_br = bready; p_bv = bvalid; p_rr = rready; p_rv = rvalid; p_rsp = rsp_valid;
      end
   end

   // ---------------- driver ----------------
   // Called with time just after a rising edge; returns in the same phase.
   task automatic issue(input bit we, input logic [1:0] idx, input logic [31:0] wd,
                        input logic [3:0] ws, input logic [1:0] resp,
                        input int unsigned d_aw, input int unsigned d_w, input int unsigned d_ar,
                        input int unsigned d_b, input int unsigned d_r, input bit hold,
                        output int unsigned acc);
      exp_t e;
      int   k = 0;
      cfg_q.push_back('{d_aw, d_w, d_ar, d_b, d_r, resp});
      e.resp = resp;
      if (we) begin
         e.rdata = 32'h0;
         e.zw = (d_aw == 0) && (d_w == 0) && (d_b == 0);
         if (resp == RespOkay)
            for (int b = 0; b < 4; b++)
               if (ws[b]) mem_ref[idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
         e.rdata = mem_ref[idx];
         e.zw = (d_ar == 0) && (d_r == 0);
      end
      cmd_valid = 1; cmd_we = we; cmd_addr = {idx, 2'b00}; cmd_wdata = wd; cmd_wstrb = ws;
      do begin
         @(negedge clk);
         k++;
      end while (!cmd_ready && k < 200);
      if (!cmd_ready) begin
         $display("FAIL cmd_accept: got cmd_ready=0 required 1 within 200 cycles");
         $fatal(1);
      end
      acc = cyc;
      e.acc = acc;
      @(posedge clk);
      #1;
      exp_q.push_back(e);
      if (!hold) begin
         cmd_valid = 0; cmd_we = 1'($urandom); cmd_addr = 4'($urandom);
         cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
      end
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      do begin
         @(posedge clk);
         k++;
      end while (exp_q.size() != 0 && k < 100);
      #1;
      if (exp_q.size() != 0) fail_now(name);
   endtask

   initial begin
      int unsigned a1, a2, gap;
      bit          we, hold;
      logic [1:0]  resp;
      aresetn = 0; cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
      for (int i = 0; i < 4; i++) begin
         mem_ref[i] = $urandom;
         slv_mem[i] = mem_ref[i];
      end
      repeat (3) @(posedge clk);
      #1 aresetn = 1;
      @(posedge clk);
      #1;

      // write 1 to register 0 with a zero-wait slave, read it back
      issue(1, 0, 32'h1, 4'hF, RespOkay, 0, 0, 0, 0, 0, 0, a1);
      wait_idle("wr0_done");
      issue(0, 0, 32'h0, 4'h0, RespOkay, 0, 0, 0, 0, 0, 0, a1);
      wait_idle("rd0_done");

      // awready late by 3 cycles, wready immediate
      aw_cyc = 0; w_cyc = 0;
      issue(1, 1, $urandom, 4'hF, RespOkay, 3, 0, 0, 0, 0, 0, a1);
      wait_idle("aw_late_done");
      chk("awvalid_cycles", aw_cyc, 4);
      chk("wvalid_cycles", w_cyc, 1);

      // slow read of addr 4
      issue(1, 1, 32'hA5A5_0002, 4'hF, RespOkay, 0, 0, 0, 0, 0, 0, a1);
      wait_idle("wr4_done");
      rr_cyc = 0;
      issue(0, 1, 32'h0, 4'h0, RespOkay, 0, 0, 0, 0, 5, 0, a1);
      wait_idle("rd4_slow_done");
      chk("rready_cycles", rr_cyc, 6);

      // back-to-back with cmd_valid held through the first transaction
      issue(1, 2, $urandom, 4'h5, RespOkay, 0, 0, 0, 0, 0, 1, a1);
      issue(0, 2, 32'h0, 4'h0, RespOkay, 0, 0, 0, 0, 0, 0, a2);
      chk("btb_accept_gap", a2 - a1, 3);
      wait_idle("btb_done");

      // reset while waiting for B, then a normal command
      issue(1, 2, $urandom, 4'hF, RespOkay, 0, 0, 0, 6, 0, 0, a1);
      gap = 0;
      do begin
         @(negedge clk);
         gap++;
      end while (!bready && gap < 20);
      if (!bready) fail_now("reach_wresp");
      @(posedge clk);
      #1 aresetn = 0;
      @(posedge clk);
      #1 aresetn = 1;
      issue(0, 2, 32'h0, 4'h0, RespOkay, 0, 0, 0, 0, 0, 0, a1);
      wait_idle("post_reset_done");

      // error responses pass straight through
      issue(1, 3, $urandom, 4'hF, RespSlverr, 0, 0, 0, 0, 0, 0, a1);
      wait_idle("slverr_done");
      issue(0, 3, 32'h0, 4'h0, RespDecerr, 0, 0, 0, 0, 0, 0, a1);
      wait_idle("decerr_done");

      for (int n = 0; n < 200; n++) begin
         we   = 1'($urandom);
         resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : RespOkay;
         hold = (n != 199) && ($urandom_range(0, 1) == 1);
         issue(we, 2'($urandom), $urandom, 4'($urandom), resp,
               ($urandom_range(0, 2) == 0) ? $urandom_range(0, 4) : 0,
               ($urandom_range(0, 2) == 0) ? $urandom_range(0, 4) : 0,
               ($urandom_range(0, 2) == 0) ? $urandom_range(0, 4) : 0,
               ($urandom_range(0, 2) == 0) ? $urandom_range(0, 4) : 0,
               ($urandom_range(0, 2) == 0) ? $urandom_range(0, 4) : 0,
               hold, a1);
         if (!hold) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin
               @(posedge clk);
               #1;
            end
         end
      end
      wait_idle("random_drain");
      chk("queue_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
